// File: rtl/fpu_cvt_sched.sv
// Two-port scheduler in front of a shared combinational int-to-bf16 converter.
// One request in flight: IDLE grants a port, CONV samples the converter, RESP holds the result.
module fpu_cvt_sched #(
    parameter int RR_EN = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [63:0]      req_int_i,
    input  logic [3:0]       req_mode_i,
    output logic [1:0]       rsp_valid_o,
    input  logic [1:0]       rsp_ready_i,
    output logic [15:0]      rsp_fp_o,
    output logic [31:0]      cvt_int_o,
    output logic [1:0]       cvt_mode_o,
    input  logic [15:0]      cvt_fp_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] done_cnt_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      op_q, op_d;
    logic [1:0]       mode_q, mode_d;
    logic             id_q, id_d;
    logic [15:0]      res_q, res_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] port_int  [2];
    logic [1:0]  port_mode [2];
    logic        grant_id;
    logic        accept;
    logic        rsp_hs;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign port_int[gi]  = req_int_i[gi*32 +: 32];
        assign port_mode[gi] = req_mode_i[gi*2 +: 2];
    end

    // Contention goes to the port not granted last (round-robin) or to port 0 (fixed).
    always_comb begin
        grant_id = 1'b0;
        if (req_valid_i == 2'b11) begin
            grant_id = (RR_EN != 0) ? ~last_q : 1'b0;
        end else begin
            grant_id = req_valid_i[1];
        end
    end

    assign accept = (state_q == S_IDLE) && (|req_valid_i) && !rst_i;
    assign rsp_hs = (state_q == S_RESP) && rsp_ready_i[id_q];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mode_d  = mode_q;
        id_d    = id_q;
        res_d   = res_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = port_int[grant_id];
                    mode_d  = port_mode[grant_id];
                    id_d    = grant_id;
                    last_d  = grant_id;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                res_d   = cvt_fp_i;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_hs) begin
                    state_d = S_IDLE;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pointer resets to 1 so port 0 wins the first contention.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            mode_q  <= '0;
            id_q    <= 1'b0;
            res_q   <= '0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mode_q  <= mode_d;
            id_q    <= id_d;
            res_q   <= res_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready_o = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid_o = (state_q == S_RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_fp_o    = (state_q == S_RESP) ? res_q : 16'h0000;
    assign cvt_int_o   = (state_q == S_CONV) ? op_q : 32'h0;
    assign cvt_mode_o  = (state_q == S_CONV) ? mode_q : 2'b00;
    assign busy_o      = (state_q != S_IDLE);
    assign done_cnt_o  = cnt_q;

endmodule

// File: tb/tb_fpu_cvt_sched.sv
// Directed bench: DUT a uses default parameters, DUT b uses fixed priority with a 2-bit counter.
// A reference int-to-bf16 converter (truncating) feeds both DUTs' converter port.
module tb_fpu_cvt_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [1:0]  a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_cvt_mode;
    logic [63:0] a_req_int;
    logic [3:0]  a_req_mode;
    logic [15:0] a_rsp_fp, a_cvt_fp, a_done;
    logic [31:0] a_cvt_int;
    logic        a_busy;

    logic [1:0]  b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_cvt_mode;
    logic [63:0] b_req_int;
    logic [3:0]  b_req_mode;
    logic [15:0] b_rsp_fp, b_cvt_fp;
    logic [1:0]  b_done;
    logic [31:0] b_cvt_int;
    logic        b_busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] sb_q[$];

    function automatic logic [15:0] ref_cvt(input logic [31:0] x);
        logic [31:0] m;
        logic [31:0] nm;
        int p;
        if (x == 32'h0) return 16'h0000;
        m = x[31] ? (~x + 32'd1) : x;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        nm = (p >= 7) ? (m >> (p - 7)) : (m << (7 - p));
        return {x[31], 8'(127 + p), nm[6:0]};
    endfunction

    assign a_cvt_fp = ref_cvt(a_cvt_int);
    assign b_cvt_fp = ref_cvt(b_cvt_int);

    fpu_cvt_sched dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
        .req_int_i(a_req_int), .req_mode_i(a_req_mode),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_fp_o(a_rsp_fp),
        .cvt_int_o(a_cvt_int), .cvt_mode_o(a_cvt_mode), .cvt_fp_i(a_cvt_fp),
        .busy_o(a_busy), .done_cnt_o(a_done)
    );

    fpu_cvt_sched #(.RR_EN(0), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
        .req_int_i(b_req_int), .req_mode_i(b_req_mode),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_fp_o(b_rsp_fp),
        .cvt_int_o(b_cvt_int), .cvt_mode_o(b_cvt_mode), .cvt_fp_i(b_cvt_fp),
        .busy_o(b_busy), .done_cnt_o(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_req_valid = 2'b00; a_rsp_ready = 2'b00; a_req_int = '0; a_req_mode = '0;
        b_req_valid = 2'b00; b_rsp_ready = 2'b00; b_req_int = '0; b_req_mode = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
    endtask

    // Scoreboard for DUT a: push on accept, pop on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_req_ready == 2'b11) chk("ready_both", {30'd0, a_req_ready}, 32'd1);
            if (a_req_ready == 2'b01) sb_q.push_back({1'b0, ref_cvt(a_req_int[31:0])});
            if (a_req_ready == 2'b10) sb_q.push_back({1'b1, ref_cvt(a_req_int[63:32])});
            if ((a_rsp_valid & a_rsp_ready) != 2'b00) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_rsp", {30'd0, a_rsp_valid}, 32'd0);
                end else begin
                    logic [16:0] e;
                    e = sb_q.pop_front();
                    chk("sb_port", {30'd0, a_rsp_valid}, e[16] ? 32'd2 : 32'd1);
                    chk("sb_fp", {16'd0, a_rsp_fp}, {16'd0, e[15:0]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_req_ready", {30'd0, a_req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, a_rsp_valid}, 32'd0);
        chk("rst_rsp_fp", {16'd0, a_rsp_fp}, 32'd0);
        chk("rst_cvt_int", a_cvt_int, 32'd0);
        chk("rst_cvt_mode", {30'd0, a_cvt_mode}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_done", {16'd0, a_done}, 32'd0);

        // Reset during CONV aborts the request
        next_cycle();
        a_req_valid = 2'b01; a_req_int[31:0] = 32'd5; a_rsp_ready = 2'b11;
        @(negedge clk);
        chk("abort_accept", {30'd0, a_req_ready}, 32'd1);
        next_cycle();
        a_req_valid = 2'b00;
        @(negedge clk);
        chk("abort_conv_busy", {31'd0, a_busy}, 32'd1);
        chk("abort_conv_int", a_cvt_int, 32'd5);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("abort_busy", {31'd0, a_busy}, 32'd0);
        chk("abort_cvt_int", a_cvt_int, 32'd0);
        chk("abort_rsp_fp", {16'd0, a_rsp_fp}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("abort_no_rsp", {30'd0, a_rsp_valid}, 32'd0);
            chk("abort_done", {16'd0, a_done}, 32'd0);
            next_cycle();
            @(negedge clk);
        end

        // Single conversion on port 0, mode forwarded
        next_cycle();
        a_req_valid = 2'b01; a_req_int[31:0] = 32'd1; a_req_mode = 4'b0010; a_rsp_ready = 2'b11;
        @(negedge clk);
        chk("s1_accept", {30'd0, a_req_ready}, 32'd1);
        next_cycle();
        a_req_valid = 2'b00; a_req_int[31:0] = 32'd99;
        @(negedge clk);
        chk("s1_cvt_int", a_cvt_int, 32'd1);
        chk("s1_cvt_mode", {30'd0, a_cvt_mode}, 32'd2);
        chk("s1_ready_conv", {30'd0, a_req_ready}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("s1_rsp_valid", {30'd0, a_rsp_valid}, 32'd1);
        chk("s1_rsp_fp", {16'd0, a_rsp_fp}, 32'h3F80);
        chk("s1_cvt_idle", a_cvt_int, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("s1_done", {16'd0, a_done}, 32'd1);
        chk("s1_busy", {31'd0, a_busy}, 32'd0);

        // Round-robin contention, request driven in first cycle after reset
        do_reset();
        a_req_valid = 2'b11; a_req_int = {32'd2, 32'hFFFF_FFFF}; a_rsp_ready = 2'b11;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            if (c % 3 == 0)
                chk($sformatf("rr_grant_c%0d", c), {30'd0, a_req_ready}, ((c / 3) % 2 == 0) ? 32'd1 : 32'd2);
            else
                chk($sformatf("rr_idle_c%0d", c), {30'd0, a_req_ready}, 32'd0);
            if (c % 3 == 2)
                chk($sformatf("rr_fp_c%0d", c), {16'd0, a_rsp_fp}, ((c / 3) % 2 == 0) ? 32'hBF80 : 32'h4000);
        end
        next_cycle();
        a_req_valid = 2'b00;
        @(negedge clk);
        chk("rr_done", {16'd0, a_done}, 32'd4);

        // Port 1 backpressure; port 0 ready must be ignored
        next_cycle();
        a_req_valid = 2'b10; a_req_int[63:32] = 32'd3; a_rsp_ready = 2'b01;
        @(negedge clk);
        chk("bp_accept", {30'd0, a_req_ready}, 32'd2);
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            @(negedge clk);
            chk("bp_hold_valid", {30'd0, a_rsp_valid}, 32'd2);
            chk("bp_hold_fp", {16'd0, a_rsp_fp}, 32'h4040);
            chk("bp_no_grant", {30'd0, a_req_ready}, 32'd0);
        end
        next_cycle();
        a_req_valid = 2'b00; a_rsp_ready = 2'b11;
        @(negedge clk);
        chk("bp_release_valid", {30'd0, a_rsp_valid}, 32'd2);
        next_cycle();
        @(negedge clk);
        chk("bp_after_valid", {30'd0, a_rsp_valid}, 32'd0);
        chk("bp_after_fp", {16'd0, a_rsp_fp}, 32'd0);
        chk("bp_done", {16'd0, a_done}, 32'd5);

        // Fixed priority and saturating 2-bit counter on DUT b
        next_cycle();
        b_req_valid = 2'b11; b_req_int = {32'd9, 32'd7}; b_rsp_ready = 2'b11;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) next_cycle();
            if (c == 15) b_req_valid = 2'b00;
            @(negedge clk);
            if (c < 15)
                chk($sformatf("fp_grant_c%0d", c), {30'd0, b_req_ready}, (c % 3 == 0) ? 32'd1 : 32'd0);
            if (c % 3 == 2) begin
                chk("fp_rsp_valid", {30'd0, b_rsp_valid}, 32'd1);
                chk("fp_rsp_fp", {16'd0, b_rsp_fp}, 32'h40E0);
            end
            if (c > 0 && c % 3 == 0)
                chk($sformatf("sat_done_c%0d", c), {30'd0, b_done}, (c / 3 > 3) ? 32'd3 : 32'(c / 3));
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_cvt_sched.md
FPU_CVT_SCHED -- requirements
Module: fpu_cvt_sched

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1; 1 = round-robin arbitration, 0 = fixed priority with port 0 winning.
REQ-002 The block SHALL have parameter CNT_W, default 16; width of the completed-conversion counter.
REQ-003 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 req_valid_i  in  2  per-port request valid; bit p belongs to port p.
REQ-006 req_ready_o  out  2  per-port request accepted this cycle.
REQ-007 req_int_i  in  2x32  per-port integer operand, two's complement.
REQ-008 req_mode_i  in  2x2  per-port mode, forwarded unchanged to the converter.
REQ-009 rsp_valid_o  out  2  per-port result valid.
REQ-010 rsp_ready_i  in  2  per-port result consumed.
REQ-011 rsp_fp_o  out  16  bf16 result; sign[15], exp[14:7], mantissa[6:0].
REQ-012 cvt_int_o  out  32  operand to the shared combinational int-to-bf16 converter.
REQ-013 cvt_mode_o  out  2  mode to the shared converter.
REQ-014 cvt_fp_i  in  16  converter result, valid in the same cycle as cvt_int_o.
REQ-015 busy_o  out  1  high whenever the FSM is not IDLE.
REQ-016 done_cnt_o  out  CNT_W  completed-conversion count.

Function
REQ-017 The FSM SHALL have three states: IDLE, CONV and RESP.
REQ-018 In IDLE with any req_valid_i set, the block SHALL assert req_ready_o for exactly one granted port, latch that port's operand, mode and port ID, and move to CONV.
REQ-019 req_ready_o SHALL be 0 in CONV and RESP, and SHALL never be 1 for both ports in the same cycle.
REQ-020 In CONV, cvt_int_o and cvt_mode_o SHALL come from the latched registers; the block SHALL capture cvt_fp_i into the result register and move to RESP.
REQ-021 In IDLE and RESP, cvt_int_o and cvt_mode_o SHALL be driven to 0.
REQ-022 In RESP, rsp_valid_o SHALL be high only for the latched port ID, with rsp_fp_o equal to the result register.
REQ-023 rsp_valid_o and rsp_fp_o SHALL be held stable until rsp_ready_i of that port is high.
REQ-024 On a RESP handshake, the FSM SHALL return to IDLE.
REQ-025 rsp_ready_i of the non-selected port SHALL be ignored.
REQ-026 A request accepted at edge N SHALL have rsp_valid_o high in the cycle after edge N+2, so minimum issue-to-issue spacing is 3 cycles.
REQ-027 rsp_fp_o SHALL be 0 whenever no rsp_valid_o bit is set.
REQ-028 Round-robin (RR_EN=1): a 1-bit last-grant pointer SHALL update on each accept.
REQ-029 Round-robin (RR_EN=1): when both ports are valid, the port not granted last SHALL win; a single valid port SHALL win regardless of the pointer.
REQ-030 Fixed priority (RR_EN=0): port 0 SHALL win whenever both ports are valid; the pointer SHALL be unused.
REQ-031 req_valid_i deasserting during CONV or RESP SHALL have no effect; the latched operand is used.
REQ-032 done_cnt_o SHALL increment by 1 on each RESP handshake and saturate at all-ones with no wrap.
REQ-033 The result register SHALL capture exactly cvt_fp_i; zero-input handling is the converter's responsibility, and the block SHALL add no special-casing.

Reset
REQ-034 While rst_i is high at a clock edge, the FSM SHALL go to IDLE.
REQ-035 While rst_i is high at a clock edge, the pointer SHALL reset so port 0 wins the first contention.
REQ-036 While rst_i is high at a clock edge, the latched operand, mode, ID, result and done_cnt_o SHALL clear to 0.
REQ-037 After reset, all outputs SHALL read 0: req_ready_o=0, rsp_valid_o=0, rsp_fp_o=0, cvt_int_o=0, cvt_mode_o=0, busy_o=0, done_cnt_o=0.
REQ-038 A reset during CONV or RESP SHALL abort the pending request with no response, no counter increment, and no retained state.
REQ-039 A request valid in the first cycle after rst_i falls SHALL be grantable in that same cycle.

Verification
REQ-040 Port 0 only, req_int_i=32'd1, rsp_ready_i=1 -> accept cycle 0; cvt_int_o=1 in cycle 1; rsp_valid_o=2'b01, rsp_fp_o=16'h3F80 in cycle 2; done_cnt_o=1.
REQ-041 Both ports valid continuously, RR_EN=1, operands -1 and 2 -> grants alternate 0,1,0,1; responses 16'hBF80 and 16'h4000; each port gets exactly one grant per 6 cycles.
REQ-042 Both ports valid continuously, RR_EN=0 -> port 0 is granted every 3 cycles; port 1 is never granted while port 0 stays valid.
REQ-043 Port 1 operand 32'd3, rsp_ready_i[1] held low for 5 cycles -> rsp_valid_o=2'b10 and rsp_fp_o=16'h4040 held stable for 5 cycles; no new grant; completes on the first rsp_ready_i high.
REQ-044 rst_i pulsed during CONV -> next cycle IDLE, all outputs 0, no rsp_valid_o, done_cnt_o unchanged from 0.
REQ-045 CNT_W=2, run 5 conversions -> done_cnt_o reads 1, 2, 3, 3, 3.
